div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider for the OpenMIPS core.
- Used by the EX stage for DIV/DIVU; EX holds the pipeline via the stall controller until ready_o.
- Result is written to HI/LO: HI = remainder, LO = quotient.
- Radix-2 restoring (trial-subtraction) algorithm, one quotient bit per cycle.

Parameters:
- none: width fixed at 32 (MIPS32 ISA); all constants come from the shared defines header.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1`); one clock, synchronous reset, active-high
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
opdata1_i  input  32  dividend; sampled with start_i
opdata2_i  input  32  divisor; sampled with start_i
start_i  input  1  request; held high by EX until ready_o seen
annul_i  input  1  cancel in-flight division (exception/flush)
result_o  output  64  {remainder[31:0], quotient[31:0]}
ready_o  output  1  result valid

Behaviour:
- Reset (rst=1 at edge): state=FREE, ready_o=0, result_o=0, counter=0, work registers cleared. Reset mid-operation aborts immediately.
- State FREE, at an edge with start_i=1 and annul_i=0:
  - Divisor==0 -> BYZERO.
  - Otherwise -> ON with cnt=0.
  - Signed mode: negative operands are replaced by their two's complement magnitude.
  - dividend reg (65 bits) = {32'b0, |opdata1|, 1'b0}; divisor reg = |opdata2|.
  - Any other input combination: stay FREE, ready_o=0, result_o=0.
- State BYZERO: next edge -> END, result_o=0, ready_o=1.
- State ON, while cnt<32, one iteration per edge, then cnt++:
  - temp = {1'b0, dividend[63:32]} - {1'b0, divisor}.
  - temp[32]=1: dividend <<= 1.
  - temp[32]=0: dividend = {temp[31:0], dividend[31:0], 1'b1}.
- State ON, cnt==32 at next edge -> END, ready_o=1:
  - quotient = dividend[31:0]; remainder = dividend[64:33].
  - Signed mode: negate quotient if the operand signs differ; negate remainder if the dividend was negative.
- Latency: taking the start-sampling edge as edge 1, ready_o is high after edge 34 for nonzero divisors and after edge 2 for zero divisors.
- State END: holds ready_o=1 and result_o stable while start_i=1. First edge with start_i=0 -> FREE, ready_o=0, result_o=0.
- annul_i=1 in ON: next edge -> FREE, ready_o=0, no result produced. annul_i in FREE blocks the start.
- Operands are not re-sampled after the start edge; input changes during ON are ignored.
- Boundary cases:
  - -2^31 / -1 (signed): quotient 0x80000000, remainder 0, no trap.
  - Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
  - Dividend < divisor: quotient 0, remainder = dividend.
- Simultaneous start_i and annul_i in FREE: annul wins, no start.

Decomposition:
- defines.v additions:
  - State codes: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - Handshake constants: DivResultReady/NotReady, DivStart/Stop.
  - Reuse the existing RstEnable, ZeroWord and RegBus definitions.
- Single module, no sub-modules: the subtractor and sign fix-up are inline combinational logic.
- EX-stage and ctrl changes (stallreq from EX while !ready_o) are tracked separately.

Test Plan:
- Unsigned 100/7 (start held) -> ready_o after edge 34, result_o = {32'd2, 32'd14}; ready_o falls one edge after start_i drops, result_o returns to 0.
- Signed -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); signed 100/-7 -> quotient -14, remainder 2.
- Divide by zero, 5/0 -> ready_o after edge 2, result_o = 0.
- annul_i pulsed at edge 10 of a 0xFFFFFFFF/3 unsigned run -> FREE, ready_o never asserts. A fresh 9/3 started afterwards -> {0, 3}.
- Signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}; unsigned 0x80000000/0xFFFFFFFF -> {0x80000000, 0}.
- rst asserted at edge 20 of an active division -> ready_o=0, result_o=0 the following cycle; the divider accepts a new start immediately after rst releases.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider.
//   - FSM state codes (DivFree/DivByZero/DivOn/DivEnd)
//   - handshake levels for start_i / ready_o
//   - reset level, zero word and register-bus width
//   - negate helper used for the two's complement fix-ups
package div_pkg;

  localparam int          RegBus            = 32;
  localparam logic        RstEnable         = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  localparam logic [1:0]  DivFree           = 2'b00;
  localparam logic [1:0]  DivByZero         = 2'b01;
  localparam logic [1:0]  DivOn             = 2'b10;
  localparam logic [1:0]  DivEnd            = 2'b11;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

  // Two's complement negate, conditional on neg.
  function automatic logic [RegBus-1:0] cond_neg(input logic neg, input logic [RegBus-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider (DIV / DIVU).
// One quotient bit per clock; result = {remainder, quotient}.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   signed_div_i 1 = signed, 0 = unsigned (sampled with start_i)
//   opdata1_i    dividend (sampled with start_i)
//   opdata2_i    divisor  (sampled with start_i)
//   start_i      request, held until ready_o
//   annul_i      cancel an in-flight division; blocks a start in FREE
//   result_o     {remainder[31:0], quotient[31:0]}
//   ready_o      result valid
module div
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [RegBus-1:0] opdata1_i,
  input  logic [RegBus-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [63:0]       result_o,
  output logic              ready_o
);

  logic [1:0]        r_state;
  logic [5:0]        r_cnt;
  logic [64:0]       r_dividend;
  logic [RegBus-1:0] r_divisor;
  logic              r_neg_q;   // operand signs differ
  logic              r_neg_r;   // dividend was negative
  logic [63:0]       r_result;
  logic              r_ready;

  logic [RegBus:0]   w_temp;
  logic [RegBus-1:0] w_abs1, w_abs2, w_quot, w_rem;

  // Trial subtraction: bit 32 set means the partial remainder is smaller
  // than the divisor, so this quotient bit is 0.
  assign w_temp = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

  assign w_abs1 = cond_neg(signed_div_i & opdata1_i[31], opdata1_i);
  assign w_abs2 = cond_neg(signed_div_i & opdata2_i[31], opdata2_i);

  // Sign fix-up uses the flags captured at start, so operand changes
  // during the run have no effect.
  assign w_quot = cond_neg(r_neg_q, r_dividend[31:0]);
  assign w_rem  = cond_neg(r_neg_r, r_dividend[64:33]);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              r_state <= DivByZero;
            end else begin
              r_state    <= DivOn;
              r_cnt      <= '0;
              r_dividend <= {32'b0, w_abs1, 1'b0};
              r_divisor  <= w_abs2;
              r_neg_q    <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              r_neg_r    <= signed_div_i & opdata1_i[31];
            end
          end
        end
        DivByZero: begin
          r_state  <= DivEnd;
          r_result <= '0;
          r_ready  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end else if (r_cnt != 6'd32) begin
            if (w_temp[32])
              r_dividend <= {r_dividend[63:0], 1'b0};
            else
              r_dividend <= {w_temp[31:0], r_dividend[31:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_state  <= DivEnd;
            r_cnt    <= '0;
            r_result <= {w_rem, w_quot};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          // Hold the result until EX drops the request.
          if (start_i == DivStop) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      q = sa / sb_;
      r = sa % sb_;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one division with start held; verify latency, result, hold
  // behaviour in END, and return to idle after start drops.
  task automatic run(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input bit mangle);
    int e;
    bit got;
    logic [63:0] exp;
    sb.push_back(model(s, a, b));
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    e = 0; got = 0;
    while (e < 60 && !got) begin
      @(posedge clk); e++; #1;
      if (mangle && e == 5) begin
        op1 = ~op1; op2 = 32'h3; signed_div = ~signed_div;
      end
      got = ready;
    end
    chk({tag, "_latency"}, 64'(e), 64'(exp_lat));
    exp = sb.pop_front();
    chk({tag, "_result"}, result, exp);
    @(posedge clk); #1;
    chk({tag, "_hold_ready"}, 64'(ready), 64'd1);
    chk({tag, "_hold_result"}, result, exp);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_ready"}, 64'(ready), 64'd0);
    chk({tag, "_drop_result"}, result, 64'h0);
  endtask

  initial begin
    int hits;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'h0);
    rst = 1'b0;

    run("u100_7",  1'b0, 32'd100, 32'd7, 34, 1'b0);
    run("s-100_7", 1'b1, -32'sd100, 32'd7, 34, 1'b1);
    run("s100_-7", 1'b1, 32'd100, -32'sd7, 34, 1'b0);
    run("div0",    1'b0, 32'd5, 32'd0, 2, 1'b0);
    run("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
    run("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 1'b0);
    run("small",   1'b0, 32'd3, 32'd10, 34, 1'b0);

    // Annul mid-run: no result ever appears.
    signed_div = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    chk("annul_no_result", 64'(hits), 64'd0);
    run("after_annul", 1'b0, 32'd9, 32'd3, 34, 1'b0);

    // start with annul in FREE must not launch.
    op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("annul_free_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    run("annul_free_then_go", 1'b0, 32'd9, 32'd3, 34, 1'b0);

    // Reset mid-run, then immediately a new start.
    signed_div = 1'b0; op1 = 32'h1234_5678; op2 = 32'd13; start = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", 64'(ready), 64'd0);
    chk("rst_mid_result", result, 64'h0);
    rst = 1'b0;
    run("after_rst", 1'b0, 32'd1000, 32'd10, 34, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
